decoder_scan_n: RTL and testbench

DECODER_SCAN_N -- requirements
Module: decoder_scan_n

---
 rtl/decoder_scan_n.sv | 186 ++++++++++++++++++
 tb/tb_decoder_scan_n.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n.sv
// Registered N-way decoder with direct select, free-running up/down scan and
// a one-shot sweep. dout, idx, busy and done all come straight from flops.
module decoder_scan_n #(
  parameter int SEL_W   = 3,
  parameter int DWELL   = 4,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  start,
  output logic [2**SEL_W-1:0]   dout,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam int N = 2**SEL_W;
  localparam logic [7:0]   DWELL_LAST = 8'(DWELL - 1);
  localparam logic [N-1:0] INACTIVE   = {N{ACT_LOW}};
  localparam logic [1:0]   M_DIRECT   = 2'b00;
  localparam logic [1:0]   M_SWEEP    = 2'b11;

  typedef enum logic [1:0] {
    ST_DIRECT  = 2'd0,
    ST_SCAN    = 2'd1,
    ST_SW_IDLE = 2'd2,
    ST_SW_RUN  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_base;
  logic [1:0]       r_mode;
  logic [SEL_W-1:0] r_idx;
  logic [7:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [N-1:0]     r_dout;

  logic [SEL_W-1:0] w_idx_nxt;
  logic [7:0]       w_cnt_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [N-1:0]     w_dout_nxt;
  logic             w_mode_chg;
  logic             w_cnt_last;
  logic             w_idx_top;
  logic             w_start_ok;

  function automatic logic [N-1:0] active_code(input logic [SEL_W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v ^ INACTIVE;
  endfunction

  assign w_mode_chg = (mode != r_mode);
  assign w_cnt_last = (r_cnt == DWELL_LAST);
  assign w_idx_top  = (r_idx == {SEL_W{1'b1}});
  // A start coinciding with the done pulse is dropped; a fresh start must follow.
  assign w_start_ok = en && start && !r_done;

  always_comb begin
    case (mode)
      M_DIRECT: w_base = ST_DIRECT;
      M_SWEEP:  w_base = ST_SW_IDLE;
      default:  w_base = ST_SCAN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_DIRECT;
      r_mode  <= M_DIRECT;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= mode;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_chg) begin
      w_state_nxt = w_base;
    end else begin
      case (r_state)
        ST_SW_IDLE: if (w_start_ok) w_state_nxt = ST_SW_RUN;
        ST_SW_RUN:  if (en && w_cnt_last && w_idx_top) w_state_nxt = ST_SW_IDLE;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    w_idx_nxt  = r_idx;
    w_cnt_nxt  = r_cnt;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    w_dout_nxt = INACTIVE;
    if (w_mode_chg) begin
      // The change cycle is dwell slot 0 of the new mode with idx held.
      w_cnt_nxt  = 8'd0;
      w_busy_nxt = 1'b0;
      if (en && (mode != M_SWEEP)) w_dout_nxt = active_code(r_idx);
    end else begin
      case (r_state)
        ST_DIRECT: begin
          w_cnt_nxt  = 8'd0;
          w_busy_nxt = 1'b0;
          if (en) begin
            w_idx_nxt  = sel;
            w_dout_nxt = active_code(sel);
          end
        end
        ST_SCAN: begin
          w_busy_nxt = 1'b0;
          if (en) begin
            if (w_cnt_last) begin
              w_cnt_nxt = 8'd0;
              w_idx_nxt = r_mode[1] ? SEL_W'(r_idx - 1'b1) : SEL_W'(r_idx + 1'b1);
            end else begin
              w_cnt_nxt = 8'(r_cnt + 8'd1);
            end
            w_dout_nxt = active_code(w_idx_nxt);
          end
        end
        ST_SW_IDLE: begin
          w_busy_nxt = 1'b0;
          if (w_start_ok) begin
            w_idx_nxt  = '0;
            w_cnt_nxt  = 8'd0;
            w_busy_nxt = 1'b1;
            w_dout_nxt = active_code('0);
          end
        end
        default: begin
          if (en) begin
            if (w_cnt_last) begin
              w_cnt_nxt = 8'd0;
              if (w_idx_top) begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
              end else begin
                w_idx_nxt  = SEL_W'(r_idx + 1'b1);
                w_dout_nxt = active_code(w_idx_nxt);
              end
            end else begin
              w_cnt_nxt  = 8'(r_cnt + 8'd1);
              w_dout_nxt = active_code(r_idx);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_cnt  <= 8'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dout <= INACTIVE;
    end else begin
      r_idx  <= w_idx_nxt;
      r_cnt  <= w_cnt_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_dout <= w_dout_nxt;
    end
  end

  assign dout      = r_dout;
  assign idx       = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Bench for decoder_scan_n: three instances (DWELL=2, ACT_LOW=1, DWELL=1) share
// stimulus; expected {dout,idx,busy,done} words are queued and popped per cycle.
module tb_decoder_scan_n;

  logic       clk = 1'b0;
  logic       rst_n, en, start;
  logic [1:0] mode;
  logic [2:0] sel;

  logic [7:0] dout, dout_al, dout_d1;
  logic [2:0] idx, idx_al, idx_d1;
  logic       busy, busy_al, busy_d1;
  logic       done, done_al, done_d1;
  logic [1:0] st, st_al, st_d1;

  logic [12:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_scan_n #(.SEL_W(3), .DWELL(2), .ACT_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .start(start),
    .dout(dout), .idx(idx), .busy(busy), .done(done), .dbg_state(st));

  decoder_scan_n #(.SEL_W(3), .DWELL(2), .ACT_LOW(1'b1)) u_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .start(start),
    .dout(dout_al), .idx(idx_al), .busy(busy_al), .done(done_al), .dbg_state(st_al));

  decoder_scan_n #(.SEL_W(3), .DWELL(1), .ACT_LOW(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .start(start),
    .dout(dout_d1), .idx(idx_d1), .busy(busy_d1), .done(done_d1), .dbg_state(st_d1));

  function automatic logic [12:0] pk(input logic [7:0] d, input int i,
                                     input logic b, input logic dn);
    return {d, 3'(i), b, dn};
  endfunction

  function automatic logic [7:0] oh(input int i);
    logic [7:0] v;
    v = 8'h01;
    return v << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] e, o;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; mode = 2'b00; sel = 3'd0;
    tick();
    exp_q.push_back(pk(8'h00, 0, 1'b0, 1'b0));
    tick();
    e = exp_q.pop_front(); o = {dout, idx, busy, done};
    total++;
    if (o !== e) begin bad++; $display("FAIL reset_main got=%h want=%h", o, e); end
    total++;
    if (st !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", st); end
    total++;
    if (dout_al !== 8'hFF) begin bad++; $display("FAIL reset_act_low got=%h want=ff", dout_al); end
    rst_n = 1'b1;
  endtask

  task automatic test_direct();
    logic [12:0] e, o;
    mode = 2'b00; en = 1'b1; start = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      exp_q.push_back(pk(oh(s), s, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); o = {dout, idx, busy, done};
      total++;
      if (o !== e) begin bad++; $display("FAIL direct_sel%0d got=%h want=%h", s, o, e); end
    end
    en = 1'b0;
    exp_q.push_back(pk(8'h00, 7, 1'b0, 1'b0));
    tick();
    e = exp_q.pop_front(); o = {dout, idx, busy, done};
    total++;
    if (o !== e) begin bad++; $display("FAIL direct_en0 got=%h want=%h", o, e); end
  endtask

  task automatic test_scan();
    logic [12:0] e, o;
    mode = 2'b00; en = 1'b1; sel = 3'd0;
    tick();
    mode = 2'b01;
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(pk(oh((k / 2) % 8), (k / 2) % 8, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); o = {dout, idx, busy, done};
      total++;
      if (o !== e) begin bad++; $display("FAIL scan_up_c%0d got=%h want=%h", k, o, e); end
    end
    mode = 2'b00; sel = 3'd0;
    tick();
    tick();
    mode = 2'b10;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(pk(oh((8 - k / 2) % 8), (8 - k / 2) % 8, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); o = {dout, idx, busy, done};
      total++;
      if (o !== e) begin bad++; $display("FAIL scan_dn_c%0d got=%h want=%h", k, o, e); end
    end
  endtask

  task automatic test_pause();
    logic [12:0] e, o;
    mode = 2'b00; sel = 3'd3; en = 1'b1;
    tick();
    tick();
    mode = 2'b01;
    tick();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) en = 1'b1;
      if (k < 3)       exp_q.push_back(pk(8'h00, 3, 1'b0, 1'b0));
      else if (k == 3) exp_q.push_back(pk(8'h08, 3, 1'b0, 1'b0));
      else             exp_q.push_back(pk(8'h10, 4, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); o = {dout, idx, busy, done};
      total++;
      if (o !== e) begin bad++; $display("FAIL pause_c%0d got=%h want=%h", k, o, e); end
    end
  endtask

  task automatic test_sweep();
    logic [12:0] e, o;
    mode = 2'b11; en = 1'b1; start = 1'b0;
    tick();
    exp_q.push_back(pk(8'h00, 4, 1'b0, 1'b0));
    tick();
    e = exp_q.pop_front(); o = {dout, idx, busy, done};
    total++;
    if (o !== e) begin bad++; $display("FAIL sweep_idle got=%h want=%h", o, e); end
    for (int k = 0; k < 16; k++) begin
      start = (k == 0 || k == 5);
      exp_q.push_back(pk(oh(k / 2), k / 2, 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front(); o = {dout, idx, busy, done};
      total++;
      if (o !== e) begin bad++; $display("FAIL sweep_c%0d got=%h want=%h", k, o, e); end
    end
    start = 1'b0;
    exp_q.push_back(pk(8'h00, 7, 1'b0, 1'b1));
    exp_q.push_back(pk(8'h00, 7, 1'b0, 1'b0));
    exp_q.push_back(pk(8'h01, 0, 1'b1, 1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      e = exp_q.pop_front(); o = {dout, idx, busy, done};
      total++;
      if (o !== e) begin bad++; $display("FAIL sweep_end_c%0d got=%h want=%h", k, o, e); end
      start = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    logic [12:0] e, o;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(pk(oh(k / 2), k / 2, 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front(); o = {dout, idx, busy, done};
      total++;
      if (o !== e) begin bad++; $display("FAIL abort_run_c%0d got=%h want=%h", k, o, e); end
    end
    mode = 2'b00; sel = 3'd5;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) exp_q.push_back(pk(8'h10, 4, 1'b0, 1'b0));
      else        exp_q.push_back(pk(8'h20, 5, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); o = {dout, idx, busy, done};
      total++;
      if (o !== e) begin bad++; $display("FAIL abort_c%0d got=%h want=%h", k, o, e); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [12:0] e, o;
    mode = 2'b11; start = 1'b0; en = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    total++;
    if (idx !== 3'd4 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre got idx=%0d busy=%b want idx=4 busy=1", idx, busy);
    end
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(pk(8'h00, 0, 1'b0, 1'b0));
      tick();
      rst_n = 1'b1;
      e = exp_q.pop_front(); o = {dout, idx, busy, done};
      total++;
      if (o !== e) begin bad++; $display("FAIL rst_mid_c%0d got=%h want=%h", k, o, e); end
    end
  endtask

  task automatic test_act_low();
    logic [12:0] e, o;
    mode = 2'b00; en = 1'b1; sel = 3'd2; start = 1'b0;
    tick();
    exp_q.push_back(pk(8'hFB, 2, 1'b0, 1'b0));
    tick();
    e = exp_q.pop_front(); o = {dout_al, idx_al, busy_al, done_al};
    total++;
    if (o !== e) begin bad++; $display("FAIL act_low_sel2 got=%h want=%h", o, e); end
    rst_n = 1'b0;
    exp_q.push_back(pk(8'hFF, 0, 1'b0, 1'b0));
    tick();
    rst_n = 1'b1;
    e = exp_q.pop_front(); o = {dout_al, idx_al, busy_al, done_al};
    total++;
    if (o !== e) begin bad++; $display("FAIL act_low_reset got=%h want=%h", o, e); end
  endtask

  task automatic test_dwell1();
    logic [12:0] e, o;
    mode = 2'b11; en = 1'b1; start = 1'b0;
    tick();
    start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) exp_q.push_back(pk(oh(k), k, 1'b1, 1'b0));
      else       exp_q.push_back(pk(8'h00, 7, 1'b0, 1'b1));
      tick();
      start = 1'b0;
      e = exp_q.pop_front(); o = {dout_d1, idx_d1, busy_d1, done_d1};
      total++;
      if (o !== e) begin bad++; $display("FAIL dwell1_sweep_c%0d got=%h want=%h", k, o, e); end
    end
    mode = 2'b01;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(pk(oh((7 + k) % 8), (7 + k) % 8, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); o = {dout_d1, idx_d1, busy_d1, done_d1};
      total++;
      if (o !== e) begin bad++; $display("FAIL dwell1_scan_c%0d got=%h want=%h", k, o, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_pause();
    test_sweep();
    test_abort();
    test_reset_mid_sweep();
    test_act_low();
    test_dwell1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
